// File: rtl/noc_pkg.sv
// noc_pkg: flit type codes, port indices, input-port FSM states and XY routing shared across the router
package noc_pkg;
  localparam logic [1:0] FT_BODY = 2'b00, FT_HEAD = 2'b01, FT_TAIL = 2'b10, FT_SINGLE = 2'b11;
  localparam logic [2:0] LOCAL = 3'd0, NORTH = 3'd1, EAST = 3'd2, SOUTH = 3'd3, WEST = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_SEND} state_t;
  function automatic logic [2:0] xy_route(input int unsigned dx, dy, x_id, y_id);
    return dx > x_id ? EAST : dx < x_id ? WEST : dy > y_id ? NORTH : dy < y_id ? SOUTH : LOCAL;
  endfunction
endpackage

// File: rtl/noc_input_port_if.sv
// noc_input_port_if: upstream flit handshake plus arbiter request/grant and crossbar handshake
interface noc_input_port_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic [DATA_W+1:0] in_flit;
  logic              in_ready;
  logic [4:0]        request;
  logic [4:0]        grant;
  logic              out_valid;
  logic [DATA_W+1:0] out_flit;
  logic              out_ready;
  logic              drop_err;
  modport master (output in_valid, in_flit, grant, out_ready,
                  input  in_ready, request, out_valid, out_flit, drop_err);
  modport slave  (input  in_valid, in_flit, grant, out_ready,
                  output in_ready, request, out_valid, out_flit, drop_err);
endinterface

// File: rtl/flit_fifo.sv
// flit_fifo: circular flit buffer with occupancy counter and pointers wrapping modulo DEPTH
module flit_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  // Storage needs no reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_din;
  // Pointers wrap explicitly so non-power-of-two depths work
  always_ff @(posedge clk)
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp == AW'(DEPTH - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rp];
endmodule

// File: rtl/noc_input_port.sv
// noc_input_port: buffers wormhole flits, XY-routes each head and forwards the packet under arbiter grant
module noc_input_port
  import noc_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          COORD_W = 3,
  parameter int          DEPTH   = 4,
  parameter int unsigned X_ID    = 0,
  parameter int unsigned Y_ID    = 0
) (
  input logic              clk,
  input logic              reset,
  noc_input_port_if.slave  p
);
  localparam int FW = DATA_W + 2;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_route, w_route_nxt;
  logic          w_full, w_empty, w_push, w_pop, w_valid, w_xfer, w_drop;
  logic [FW-1:0] w_head;
  logic [1:0]    w_type;
  assign w_type = w_head[FW-1:DATA_W];
  assign w_push = p.in_valid && !w_full;
  flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .i_push(w_push), .i_pop(w_pop), .i_din(p.in_flit),
    .o_full(w_full), .o_empty(w_empty), .o_head(w_head)
  );
  // Packet state and the output chosen by the current packet's head
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_route <= LOCAL;
    end else begin
      r_state <= w_state_nxt;
      r_route <= w_route_nxt;
    end
  // Handshakes, orphan-flit dropping and next state; mid-packet heads are forwarded unrouted
  always_comb begin
    w_valid      = r_state != S_IDLE && !w_empty && p.grant[r_route];
    w_xfer       = w_valid && p.out_ready;
    w_drop       = r_state == S_IDLE && !w_empty && !w_type[0];
    w_pop        = w_xfer || w_drop;
    p.in_ready   = !w_full;
    p.out_flit   = w_head;
    p.out_valid  = w_valid;
    p.drop_err   = w_drop;
    p.request    = r_state == S_IDLE ? 5'b0 : 5'b1 << r_route;
    w_state_nxt  = r_state;
    w_route_nxt  = r_route;
    if (r_state == S_IDLE && !w_empty && w_type[0]) begin
      w_state_nxt = S_REQUEST;
      w_route_nxt = xy_route(32'(w_head[COORD_W-1:0]), 32'(w_head[2*COORD_W-1:COORD_W]), X_ID, Y_ID);
    end else if (r_state == S_REQUEST && w_xfer)
      w_state_nxt = w_type == FT_SINGLE ? S_IDLE : S_SEND;
    else if (r_state == S_SEND && w_xfer && w_type == FT_TAIL)
      w_state_nxt = S_IDLE;
  end
endmodule

// File: tb/tb_noc_input_port.sv
// tb_noc_input_port: randomized packet traffic against a packet-level scoreboard plus directed timing checks
module tb_noc_input_port;
  localparam int DW = 32;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  noc_input_port_if #(.DATA_W(DW)) bus();
  noc_input_port #(.DATA_W(DW), .COORD_W(3), .DEPTH(4), .X_ID(2), .Y_ID(2)) dut (
    .clk(clk), .reset(reset), .p(bus)
  );

  typedef struct {logic [DW+1:0] flit; logic [4:0] req; bit drop;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int g_mode = 1, r_mode = 1;
  bit mon_en = 0, in_pkt = 0;
  logic [4:0] pkt_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_req(input int dx, input int dy);
    if (dx != 2) return dx > 2 ? 5'b00100 : 5'b10000;
    if (dy != 2) return dy > 2 ? 5'b00010 : 5'b01000;
    return 5'b00001;
  endfunction

  function automatic logic [DW+1:0] mk(input logic [1:0] t, input int x, input int y);
    logic [DW-1:0] v;
    v = $urandom;
    v[2:0] = x[2:0];
    v[5:3] = y[2:0];
    return {t, v};
  endfunction

  task automatic model_push(input logic [DW+1:0] f);
    logic [1:0] t;
    exp_t e;
    t = f[DW+1:DW];
    e.flit = f;
    e.drop = 0;
    if (!in_pkt) begin
      if (t == 2'b00 || t == 2'b10) begin
        e.drop = 1;
        e.req = 0;
      end else begin
        pkt_req = ref_req(int'(f[2:0]), int'(f[5:3]));
        e.req = pkt_req;
        in_pkt = t == 2'b01;
      end
    end else begin
      e.req = pkt_req;
      in_pkt = t != 2'b10;
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [DW+1:0] f);
    int n = 0;
    bus.in_flit = f;
    bus.in_valid = 1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    model_push(f);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Arbiter model: grant appears after a random delay and is held while the request stays up
  always @(posedge clk) begin
    #1;
    if (g_mode == 0) begin
      if (bus.request == 0) bus.grant = 0;
      else if ((bus.grant & bus.request) == 0) bus.grant = $urandom_range(0, 2) == 0 ? bus.request : 5'b0;
    end else bus.grant = g_mode == 1 ? 5'b11111 : 5'b0;
    bus.out_ready = r_mode == 2 ? 1'($urandom_range(0, 1)) : r_mode == 1;
  end

  // Monitor: compares each transfer or drop with the oldest expected flit
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    if (bus.out_valid) chk("grant_held", |(bus.grant & bus.request), 1);
    if (bus.request != 0 && exp_q.size() > 0) chk("request", bus.request, exp_q[0].req);
    if ((bus.out_valid && bus.out_ready) || bus.drop_err) begin
      if (exp_q.size() == 0) chk("unexpected_output", bus.out_flit, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_flit", bus.out_flit, e.flit);
        chk("dropped", bus.drop_err, e.drop);
      end
    end
  end

  initial begin
    logic [DW+1:0] f;
    int kind, nb, x, y;
    bus.in_valid = 0;
    bus.in_flit = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_request", bus.request, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_drop_err", bus.drop_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    mon_en = 1;

    send(mk(2'b11, 2, 2));
    chk("lat1_request", bus.request, 0);
    idle(1);
    chk("lat2_request", bus.request, 5'b00001);
    chk("lat2_out_valid", bus.out_valid, 1);
    idle(1);
    chk("lat3_request", bus.request, 0);
    chk("lat3_out_valid", bus.out_valid, 0);

    g_mode = 2;
    send(mk(2'b01, 4, 0));
    send(mk(2'b00, 0, 0));
    send(mk(2'b00, 0, 0));
    send(mk(2'b10, 0, 0));
    chk("full_in_ready", bus.in_ready, 0);
    f = mk(2'b11, 0, 0);
    bus.in_flit = f;
    bus.in_valid = 1;
    repeat (3) begin
      chk("held_in_ready", bus.in_ready, 0);
      chk("held_request", bus.request, 5'b00100);
      chk("held_out_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    g_mode = 1;
    send(f);
    drain();
    idle(2);
    chk("after_pkt_request", bus.request, 0);

    send(mk(2'b00, 1, 1));
    chk("drop_pulse", bus.drop_err, 1);
    chk("drop_request", bus.request, 0);
    idle(1);
    chk("drop_once", bus.drop_err, 0);
    chk("drop_request2", bus.request, 0);

    send(mk(2'b11, 3, 0));
    send(mk(2'b11, 1, 5));
    send(mk(2'b11, 2, 3));
    send(mk(2'b11, 2, 1));
    drain();

    send(mk(2'b01, 5, 5));
    send(mk(2'b00, 0, 0));
    r_mode = 0;
    send(mk(2'b00, 0, 0));
    idle(2);
    chk("send_request", bus.request, 5'b00100);
    mon_en = 0;
    reset = 1;
    @(negedge clk);
    chk("mid_rst_request", bus.request, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    reset = 0;
    exp_q.delete();
    in_pkt = 0;
    r_mode = 1;
    mon_en = 1;
    send(mk(2'b01, 0, 3));
    send(mk(2'b10, 0, 0));
    drain();

    g_mode = 0;
    r_mode = 2;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 7);
      if (kind == 0) send(mk($urandom_range(0, 1) ? 2'b00 : 2'b10, x, y));
      else if (kind < 4) send(mk(2'b11, x, y));
      else begin
        nb = $urandom_range(0, 3);
        send(mk(2'b01, x, y));
        for (int j = 0; j < nb; j++) send(mk($urandom_range(0, 3) == 0 ? 2'b01 : 2'b00, 0, 0));
        send(mk(2'b10, 0, 0));
      end
      idle($urandom_range(0, 2));
    end
    drain();
    idle(2);
    chk("final_request", bus.request, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_input_port.md
# noc_input_port

Input-port unit of the 5-port NoC router and the requesting side of the per-output round-robin arbiters. It buffers incoming wormhole flits in a small FIFO, computes an XY route from each head flit, and raises a one-hot request to the arbiter of the chosen output. The request stays high until the packet's tail leaves, and flits are forwarded to the crossbar only while that arbiter's grant is held.

## Interface
- DATA_W, 32, flit payload width; the full flit is DATA_W+2 bits.
- COORD_W, 3, width of each destination coordinate field.
- DEPTH, 4, number of FIFO entries (≥2).
- X_ID, 0, this router's X coordinate.
- Y_ID, 0, this router's Y coordinate.
- clk  input  1  clock; one clock domain; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream flit valid.
- in_flit  input  DATA_W+2  upstream flit: [DATA_W+1:DATA_W] type, [DATA_W-1:0] payload.
- in_ready  output  1  this port can accept a flit; equals !full.
- request  output  5  one-hot request to the output arbiters; bit 0 local, 1 north, 2 east, 3 south, 4 west.
- grant  input  5  bit j high when output j's arbiter grants this port.
- out_valid  output  1  flit at FIFO head is presented to the crossbar.
- out_flit  output  DATA_W+2  FIFO head flit.
- out_ready  input  1  the selected output accepts the flit this cycle.
- drop_err  output  1  one-cycle pulse when a non-head flit is discarded in IDLE.

## Operation
- Flit types: 2'b00 body, 2'b01 head, 2'b10 tail, 2'b11 single (head and tail).
- A head or single flit carries dest_x = payload[COORD_W-1:0] and dest_y = payload[2*COORD_W-1:COORD_W], both unsigned.
- XY route, X first:
  - dest_x > X_ID → east; dest_x < X_ID → west.
  - Otherwise dest_y > Y_ID → north; dest_y < Y_ID → south.
  - Otherwise local.
- Push when in_valid && in_ready. Pop when out_valid && out_ready. The occupancy counter is $clog2(DEPTH+1) bits, and the read/write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - FIFO empty → stay.
    - Front is head or single → latch route_reg and go to REQUEST.
    - Front is body or tail → pop it, pulse drop_err, stay in IDLE.
  - REQUEST: request = onehot(route_reg). When grant[route_reg] && out_ready, the head transfers. A single flit goes to IDLE; a head flit goes to SEND.
  - SEND: request held. Each transfer pops one flit. Transfer of a tail goes to IDLE. A head or single flit seen in SEND is forwarded as body; no re-route.
- out_valid = (state is REQUEST or SEND) && !empty && grant[route_reg].
- out_flit always shows the FIFO head.
- Arbiter contract: grant[j] stays high while request[j] stays high. The block never transfers without the grant.

## Timing
- Reset values: request=0, out_valid=0, drop_err=0, in_ready=1. FIFO is emptied, state is IDLE, route_reg=0.
- Reset mid-packet: all buffered flits are discarded and request drops the cycle after reset is sampled.
- No bypass path. A flit pushed at edge t is at the FIFO front in cycle t+1. route_reg latches at edge t+1. request is high in cycle t+2.
- With grant and out_ready already high, the head leaves in cycle t+2, so minimum latency is 2 cycles. After that, one flit per cycle.
- request drops in the cycle after the tail transfer (registered state). A following head then needs one IDLE cycle before it requests again.
- Full FIFO: in_ready=0, even if a pop occurs in the same cycle.
- Empty in SEND: out_valid=0 and request stays high until the tail arrives.
- Simultaneous push and pop: both occur and the count is unchanged.

## Structure
- Shared package noc_pkg holds:
  - flit type codes;
  - port index constants (LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4);
  - FSM state encoding;
  - the xy_route function, shared with the router top.
- One sub-module, flit_fifo: parameterised DEPTH/width; exposes push, pop, full, empty and head.
- FSM, route register and request/handshake logic live in noc_input_port.

## Test plan
- Single flit at X_ID=Y_ID=0 with dest (0,0), grant held high, out_ready=1 → request=5'b00001 in cycle t+2, out_valid for one cycle, request back to 0 at t+3.
- 4-flit packet (head dest (2,0), 2 body, tail), grant delayed 3 cycles → request=5'b00100 held throughout, no out_valid before grant, then 4 consecutive transfers in order and request cleared after the tail.
- Push 5 flits with grant=0, DEPTH=4 → in_ready=0 after the 4th push; 5th flit held off; no data loss once grant rises.
- Body flit arriving while IDLE → drop_err pulses once, FIFO pops it, request stays 0.
- Route sweep with X_ID=Y_ID=2 over dest (3,0), (1,5), (2,3), (2,1) → request 5'b00100, 5'b10000, 5'b00010, 5'b01000.
- reset asserted mid-packet in SEND → next cycle request=0, out_valid=0, in_ready=1; a fresh packet after reset routes normally.
